pipe_stall_ctrl: RTL

Central stall/bubble scheduler for the 5-stage MIPS pipeline (PC, IF, ID, EX, MEM, WB). It takes the load-use request from ID, the multi-cycle divide request from EX and the data-SRAM wait from MEM, and produces the shared stall bus. It also sequences the divider with a start pulse, a busy/done FSM and a watchdog, and drives ID's instruction-hold flag. All stage registers consume its stall bus.

---
 rtl/pipe_stall_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/pipe_stall_ctrl.sv
// Central stall/bubble scheduler for the 5-stage pipeline: merges load-use,
// divide and data-SRAM wait requests into one stall bus and sequences the divider.
module pipe_stall_ctrl #(
  parameter int STALL_W     = 6,
  parameter int DIV_MAX_CYC = 40,
  parameter int CNT_W       = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stallreq_from_id_i,
  input  logic               ex_div_req_i,
  input  logic               div_ready_i,
  input  logic               mem_wait_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               div_start_o,
  output logic               div_busy_o,
  output logic               div_timeout_o,
  output logic               id_hold_o,
  output logic [CNT_W-1:0]   stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } state_e;

  localparam logic [STALL_W-1:0] STALL_MEM  = STALL_W'(6'b011111);
  localparam logic [STALL_W-1:0] STALL_DIV  = STALL_W'(6'b001111);
  localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(6'b000111);
  localparam logic [5:0]         DIV_LIMIT  = 6'(DIV_MAX_CYC - 1);

  state_e             state_q, state_d;
  logic [5:0]         div_cyc_q, div_cyc_d;
  logic               div_timeout_q, div_timeout_d;
  logic               id_hold_q, id_hold_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               div_stall_s;
  logic               div_start_s;
  logic               div_busy_s;
  logic [STALL_W-1:0] stall_s;

  // Divider sequencing: next state, cycle counter, watchdog and divide-stall request.
  always_comb begin
    state_d       = state_q;
    div_cyc_d     = div_cyc_q;
    div_timeout_d = div_timeout_q;
    div_stall_s   = 1'b0;
    div_start_s   = 1'b0;
    div_busy_s    = 1'b0;
    case (state_q)
      IDLE: begin
        // A launch is deferred while MEM holds, so the divider never starts on a frozen EX.
        if (ex_div_req_i && !mem_wait_i) begin
          div_start_s = 1'b1;
          div_stall_s = 1'b1;
          div_cyc_d   = 6'd0;
          state_d     = DIV_RUN;
        end else begin
          state_d = IDLE;
        end
      end
      DIV_RUN: begin
        div_busy_s  = 1'b1;
        div_stall_s = 1'b1;
        div_cyc_d   = div_cyc_q + 6'd1;
        if (div_ready_i) begin
          state_d = DIV_DONE;
        end else if (div_cyc_q == DIV_LIMIT) begin
          div_timeout_d = 1'b1;
          state_d       = DIV_DONE;
        end else begin
          state_d = DIV_RUN;
        end
      end
      DIV_DONE: begin
        if (!mem_wait_i) begin
          state_d = IDLE;
        end else begin
          state_d = DIV_DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall bus priority: SRAM wait, then divide, then load-use; forced quiet under reset.
  always_comb begin
    stall_s = '0;
    if (rst_i) begin
      stall_s = '0;
    end else if (mem_wait_i) begin
      stall_s = STALL_MEM;
    end else if (div_stall_s) begin
      stall_s = STALL_DIV;
    end else if (stallreq_from_id_i) begin
      stall_s = STALL_LOAD;
    end else begin
      stall_s = '0;
    end
  end

  // Registered side effects of the stall bus: ID hold flag and saturating stall counter.
  always_comb begin
    id_hold_d   = stall_s[2];
    stall_cnt_d = stall_cnt_q;
    if (stall_s[0] && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      div_cyc_q     <= 6'd0;
      div_timeout_q <= 1'b0;
      id_hold_q     <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      div_cyc_q     <= div_cyc_d;
      div_timeout_q <= div_timeout_d;
      id_hold_q     <= id_hold_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign stall_o       = stall_s;
  assign div_start_o   = div_start_s & ~rst_i;
  assign div_busy_o    = div_busy_s & ~rst_i;
  assign div_timeout_o = div_timeout_q;
  assign id_hold_o     = id_hold_q;
  assign stall_cnt_o   = stall_cnt_q;

endmodule
